// File: rtl/arith_acc.sv
// Signed add/subtract accumulator with optional saturation, sticky
// overflow and a saturating operation counter; one-cycle latency.
module arith_acc #(
   parameter int WIDTH = 8,
   parameter bit SAT   = 1'b0,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             SUB,
   input  logic             ACC,
   input  logic             clr_acc,
   output logic             out_vld,
   output logic [WIDTH-1:0] SUM,
   output logic             OV,
   output logic             OV_STKY,
   output logic [CNT_W-1:0] OPS
);

   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] opa, effb, raw, res;
   logic             ov_q, ov_d;
   logic             stky_q, stky_d, stky_base;
   logic             vld_q, vld_d;
   logic             ovf;
   logic [CNT_W-1:0] ops_q, ops_d, ops_base;

   always_comb begin
      // a same-cycle clear is applied before the operation sees the state
      opa       = ACC ? (clr_acc ? '0 : sum_q) : A;
      effb      = SUB ? ~B : B;
      raw       = opa + effb + {{(WIDTH-1){1'b0}}, SUB};
      ovf       = (opa[WIDTH-1] == effb[WIDTH-1]) &&
                  (raw[WIDTH-1] != opa[WIDTH-1]);
      res       = raw;
      if (SAT && ovf) begin
         res = opa[WIDTH-1] ? MAX_NEG : MAX_POS;
      end
      ops_base  = clr_acc ? '0 : ops_q;
      stky_base = clr_acc ? 1'b0 : stky_q;
      sum_d     = clr_acc ? '0 : sum_q;
      ov_d      = clr_acc ? 1'b0 : ov_q;
      stky_d    = stky_base;
      ops_d     = ops_base;
      vld_d     = 1'b0;
      if (in_vld) begin
         sum_d  = res;
         ov_d   = ovf;
         stky_d = stky_base | ovf;
         ops_d  = (&ops_base) ? ops_base : ops_base + CNT_W'(1);
         vld_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= '0;
         ov_q   <= 1'b0;
         stky_q <= 1'b0;
         ops_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         ov_q   <= ov_d;
         stky_q <= stky_d;
         ops_q  <= ops_d;
         vld_q  <= vld_d;
      end
   end

   assign SUM     = sum_q;
   assign OV      = ov_q;
   assign OV_STKY = stky_q;
   assign OPS     = ops_q;
   assign out_vld = vld_q;

endmodule

// File: tb/tb_arith_acc.sv
// Bench for arith_acc: wrap and saturate instances side by side,
// vector table, reference model scoreboard and async reset sequence.
module tb_arith_acc;

   typedef struct packed {
      logic [7:0] sum0;
      logic       ov0;
      logic [7:0] sum1;
      logic       ov1;
      logic [7:0] ops;
      logic       stky0;
      logic       stky1;
   } exp_t;

   typedef struct packed {
      logic       vld;
      logic       clr;
      logic       acc;
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_vld = 1'b0;
   logic [7:0] in_a = '0;
   logic [7:0] in_b = '0;
   logic       in_sub = 1'b0;
   logic       in_acc = 1'b0;
   logic       in_clr = 1'b0;

   logic       vld0, ov0, stky0;
   logic [7:0] sum0, ops0;
   logic       vld1, ov1, stky1;
   logic [7:0] sum1, ops1;

   int checks = 0;
   int errors = 0;

   exp_t q[$];
   vec_t tbl[18];

   logic [7:0] m_sum[2];
   logic       m_ov[2];
   logic       m_stky[2];
   logic [7:0] m_ops;

   always #5 clk = ~clk;

   arith_acc #(.WIDTH(8), .SAT(1'b0), .CNT_W(8)) u_wrap (
      .clk(clk), .rst(rst), .in_vld(in_vld), .A(in_a), .B(in_b),
      .SUB(in_sub), .ACC(in_acc), .clr_acc(in_clr),
      .out_vld(vld0), .SUM(sum0), .OV(ov0), .OV_STKY(stky0), .OPS(ops0)
   );

   arith_acc #(.WIDTH(8), .SAT(1'b1), .CNT_W(8)) u_sat (
      .clk(clk), .rst(rst), .in_vld(in_vld), .A(in_a), .B(in_b),
      .SUB(in_sub), .ACC(in_acc), .clr_acc(in_clr),
      .out_vld(vld1), .SUM(sum1), .OV(ov1), .OV_STKY(stky1), .OPS(ops1)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic chk_state(input string tag, input exp_t e);
      chk({tag, " sum0"}, 32'(sum0), 32'(e.sum0));
      chk({tag, " ov0"}, 32'(ov0), 32'(e.ov0));
      chk({tag, " sum1"}, 32'(sum1), 32'(e.sum1));
      chk({tag, " ov1"}, 32'(ov1), 32'(e.ov1));
      chk({tag, " ops0"}, 32'(ops0), 32'(e.ops));
      chk({tag, " ops1"}, 32'(ops1), 32'(e.ops));
      chk({tag, " stky0"}, 32'(stky0), 32'(e.stky0));
      chk({tag, " stky1"}, 32'(stky1), 32'(e.stky1));
   endtask

   task automatic step(input string tag, input vec_t v);
      exp_t got;
      @(negedge clk);
      in_vld = v.vld;
      in_clr = v.clr;
      in_acc = v.acc;
      in_sub = v.sub;
      in_a   = v.a;
      in_b   = v.b;
      if (v.vld) q.push_back(v.e);
      @(posedge clk);
      #1;
      chk({tag, " out_vld0"}, 32'(vld0), 32'(v.vld));
      chk({tag, " out_vld1"}, 32'(vld1), 32'(v.vld));
      if (vld0) begin
         if (q.size() == 0) begin
            chk({tag, " queue"}, 32'(0), 32'(1));
         end else begin
            got = q.pop_front();
            chk_state(tag, got);
         end
      end else begin
         chk_state(tag, v.e);
      end
      in_vld = 1'b0;
      in_clr = 1'b0;
   endtask

   function automatic vec_t mk(
      input logic vld, clr, acc, sub, input logic [7:0] a, b,
      input logic [7:0] s0, input logic o0, input logic [7:0] s1,
      input logic o1, input logic [7:0] ops, input logic st);
      vec_t v;
      v.vld = vld; v.clr = clr; v.acc = acc; v.sub = sub;
      v.a = a; v.b = b;
      v.e.sum0 = s0; v.e.ov0 = o0; v.e.sum1 = s1; v.e.ov1 = o1;
      v.e.ops = ops; v.e.stky0 = st; v.e.stky1 = st;
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_sum[k] = '0; m_ov[k] = 1'b0; m_stky[k] = 1'b0;
      end
      m_ops = '0;
   endtask

   // integer-domain reference: overflow is range escape of the true result
   task automatic model(inout vec_t v);
      int sa, sb, r;
      logic ov;
      if (v.clr) model_reset();
      if (v.vld) begin
         for (int k = 0; k < 2; k++) begin
            sa = v.acc ? int'($signed(m_sum[k])) : int'($signed(v.a));
            sb = int'($signed(v.b));
            r  = v.sub ? sa - sb : sa + sb;
            ov = (r > 127) || (r < -128);
            if (k == 1 && ov) m_sum[k] = (r > 127) ? 8'h7F : 8'h80;
            else m_sum[k] = 8'(r);
            m_ov[k] = ov;
            m_stky[k] = m_stky[k] | ov;
         end
         if (m_ops != 8'hFF) m_ops = m_ops + 8'd1;
      end
      v.e.sum0 = m_sum[0]; v.e.ov0 = m_ov[0];
      v.e.sum1 = m_sum[1]; v.e.ov1 = m_ov[1];
      v.e.ops = m_ops; v.e.stky0 = m_stky[0]; v.e.stky1 = m_stky[1];
   endtask

   task automatic rand_op(input string tag, input logic clr_ok,
                          input logic force_vld);
      vec_t v;
      v = '0;
      v.vld = force_vld ? 1'b1 : ($urandom_range(0, 3) != 0);
      v.clr = clr_ok && ($urandom_range(0, 31) == 0);
      v.acc = force_vld ? 1'b0 : 1'($urandom_range(0, 1));
      v.sub = 1'($urandom_range(0, 1));
      v.a   = 8'($urandom_range(0, 255));
      v.b   = 8'($urandom_range(0, 255));
      model(v);
      step(tag, v);
   endtask

   initial begin
      exp_t zero_e;
      vec_t v;
      zero_e = '0;

      tbl[0]  = mk(0,1,0,0,8'h00,8'h00, 8'h00,0,8'h00,0, 8'd0,0);
      tbl[1]  = mk(1,0,0,0,8'h5A,8'h5A, 8'hB4,1,8'h7F,1, 8'd1,1);
      tbl[2]  = mk(1,0,0,1,8'h80,8'h01, 8'h7F,1,8'h80,1, 8'd2,1);
      tbl[3]  = mk(1,0,0,1,8'h00,8'h80, 8'h80,1,8'h7F,1, 8'd3,1);
      tbl[4]  = mk(0,1,0,0,8'h00,8'h00, 8'h00,0,8'h00,0, 8'd0,0);
      tbl[5]  = mk(1,0,1,0,8'h00,8'h10, 8'h10,0,8'h10,0, 8'd1,0);
      tbl[6]  = mk(1,0,1,0,8'h00,8'h10, 8'h20,0,8'h20,0, 8'd2,0);
      tbl[7]  = mk(1,0,1,0,8'h00,8'h10, 8'h30,0,8'h30,0, 8'd3,0);
      tbl[8]  = mk(1,0,1,1,8'h00,8'h30, 8'h00,0,8'h00,0, 8'd4,0);
      tbl[9]  = mk(1,0,0,0,8'h7F,8'h01, 8'h80,1,8'h7F,1, 8'd5,1);
      tbl[10] = mk(1,0,0,0,8'h01,8'hFE, 8'hFF,0,8'hFF,0, 8'd6,1);
      tbl[11] = mk(0,0,0,0,8'h33,8'h44, 8'hFF,0,8'hFF,0, 8'd6,1);
      tbl[12] = mk(0,0,1,1,8'h55,8'h66, 8'hFF,0,8'hFF,0, 8'd6,1);
      tbl[13] = mk(0,0,0,0,8'h77,8'h88, 8'hFF,0,8'hFF,0, 8'd6,1);
      tbl[14] = mk(0,1,0,0,8'h00,8'h00, 8'h00,0,8'h00,0, 8'd0,0);
      tbl[15] = mk(1,0,0,0,8'h30,8'h00, 8'h30,0,8'h30,0, 8'd1,0);
      tbl[16] = mk(1,1,1,0,8'h00,8'h05, 8'h05,0,8'h05,0, 8'd1,0);
      tbl[17] = mk(1,0,0,1,8'hFF,8'h80, 8'h7F,0,8'h7F,0, 8'd2,0);

      // reset is asynchronous: outputs are zero before any edge
      #3;
      chk("rst out_vld", 32'(vld0 | vld1), 32'(0));
      chk_state("rst", zero_e);
      @(posedge clk);
      #1;
      chk_state("rst edge", zero_e);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         step($sformatf("vec%0d", i), tbl[i]);
      end

      v = '0;
      v.clr = 1'b1;
      model_reset();
      model(v);
      step("rnd clr", v);
      for (int i = 0; i < 200; i++) begin
         rand_op($sformatf("rnd%0d", i), 1'b1, 1'b0);
      end

      v = '0;
      v.clr = 1'b1;
      model(v);
      step("ops clr", v);
      for (int i = 0; i < 258; i++) begin
         rand_op($sformatf("ops%0d", i), 1'b0, 1'b1);
      end
      chk("ops saturated", 32'(ops0), 32'hFF);

      // reset mid-cycle during a back-to-back stream
      v = '0; v.vld = 1'b1; v.a = 8'h21; v.b = 8'h11;
      model(v);
      step("pre rst", v);
      @(negedge clk);
      in_vld = 1'b1; in_a = 8'h11; in_b = 8'h22;
      in_sub = 1'b0; in_acc = 1'b0; in_clr = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async out_vld", 32'(vld0 | vld1), 32'(0));
      chk_state("async", zero_e);
      q.delete();
      @(posedge clk);
      #1;
      chk("rst hold out_vld", 32'(vld0 | vld1), 32'(0));
      chk_state("rst hold", zero_e);
      @(negedge clk);
      rst = 1'b0;
      in_vld = 1'b0;
      @(posedge clk);
      #1;
      chk("post rst out_vld", 32'(vld0 | vld1), 32'(0));
      chk_state("post rst", zero_e);
      model_reset();
      v = '0; v.vld = 1'b1; v.a = 8'h12; v.b = 8'h34;
      model(v);
      chk("post rst model sum", 32'(v.e.sum0), 32'h46);
      step("first op", v);
      chk("first op ops", 32'(ops0), 32'd1);

      chk("queue drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/arith_acc.md
ARITH_ACC -- requirements
Module: arith_acc

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits, two's complement, legal range 2..32.
REQ-002 Parameter SAT, default 0, 0 = wrap-around result on overflow, 1 = saturate result on overflow.
REQ-003 Parameter CNT_W, default 8, width of the operation counter.
REQ-004 clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_vld  input  1  operation request; an operation is accepted only in a cycle where in_vld=1.
REQ-007 A  input  WIDTH  first operand, used when ACC=0.
REQ-008 B  input  WIDTH  second operand.
REQ-009 SUB  input  1  0 = add, 1 = subtract (operand_A - B).
REQ-010 ACC  input  1  1 = accumulate mode: operand_A is the current SUM register, not A.
REQ-011 clr_acc  input  1  synchronous clear of SUM, OV_STKY and OPS.
REQ-012 out_vld  output  1  high for exactly one cycle after each accepted operation.
REQ-013 SUM  output  WIDTH  registered result, also the accumulator.
REQ-014 OV  output  1  signed overflow flag of the most recent accepted operation.
REQ-015 OV_STKY  output  1  sticky overflow, set by any overflowing operation.
REQ-016 OPS  output  CNT_W  count of accepted operations since the last clear.

Function
REQ-017 Latency is 1 cycle: an operation accepted on edge N drives SUM, OV and out_vld=1 after edge N.
REQ-018 Effective B is B when SUB=0 and ~B with carry-in 1 when SUB=1; the raw sum is WIDTH bits with the carry-out discarded.
REQ-019 OV shall be 1 when operand_A and effective B have equal MSBs and the raw sum MSB differs from them; subtracting the most-negative value therefore overflows unless operand_A is negative.
REQ-020 With SAT=0, SUM shall load the raw sum.
REQ-021 With SAT=1 and OV=1, SUM shall load the most-positive value (0x7F at WIDTH=8) when operand_A MSB is 0, and the most-negative value (0x80) when it is 1.
REQ-022 With SAT=1 and OV=0, SUM shall load the raw sum.
REQ-023 When in_vld=0, SUM, OV and OPS shall hold, and out_vld shall be 0 next cycle.
REQ-024 OV_STKY shall be set by an accepted overflowing operation and held until clr_acc or rst; OV alone reflects only the latest operation.
REQ-025 OPS shall increment per accepted operation and saturate at all-ones, with no wrap-around.
REQ-026 clr_acc=1 with in_vld=0 shall clear SUM, OV, OV_STKY and OPS to 0 on the next edge, with out_vld=0.
REQ-027 clr_acc=1 with in_vld=1 in the same cycle: clear first, then the operation.
  - operand_A = 0 when ACC=1, A when ACC=0.
  - Result is loaded as in REQ-020/021; OV and OV_STKY reflect only this operation.
  - OPS=1 and out_vld=1.
REQ-028 The block has no back-pressure: an operation is accepted every cycle in_vld=1, and back-to-back accumulate operations use the SUM from the immediately preceding operation.

Reset
REQ-029 While rst=1, SUM=0, OV=0, OV_STKY=0, OPS=0 and out_vld=0, independent of clk.
REQ-030 An operation in flight when rst asserts shall be discarded, and no out_vld pulse shall follow rst deassertion.
REQ-031 The first edge with rst=0 shall accept an operation normally.

Verification (WIDTH=8)
REQ-032 Wrap (SAT=0): A=0x5A, B=0x5A, SUB=0, in_vld=1 -> next cycle SUM=0xB4, OV=1, out_vld=1.
REQ-033 Saturate (SAT=1): the same stimulus -> SUM=0x7F, OV=1.
  - A=0x80, B=0x01, SUB=1 -> SUM=0x80, OV=1.
  - A=0x00, B=0x80, SUB=1 -> SUM=0x7F, OV=1.
REQ-034 Accumulate: clr_acc, then ACC=1, B=0x10, SUB=0 for three consecutive cycles -> SUM=0x10, 0x20, 0x30, OPS=3.
  - Then SUB=1, B=0x30 -> SUM=0x00, OV=0, OPS=4.
REQ-035 Sticky and hold: A=0x7F, B=0x01 (OV=1), then A=0x01, B=0xFE, SUB=0 -> SUM=0xFF, OV=0, OV_STKY=1.
  - Then in_vld=0 for 3 cycles -> SUM=0xFF held, out_vld=0.
  - Then clr_acc -> all outputs 0.
REQ-036 Simultaneous clear: SUM=0x30, clr_acc=1, in_vld=1, ACC=1, B=0x05, SUB=0 -> SUM=0x05, OPS=1, out_vld=1.
REQ-037 Async reset: assert rst between edges during a back-to-back stream -> outputs reach 0 before the next edge.
  - First accepted operation after release: SUM=A+B, OPS=1.
